// File: rtl/xillybus_rd_framer.sv
// Frames 32-bit readout words as header/payload/trailer and buffers them in a
// FIFO read by the Xillybus core through its user_r_* read-FIFO interface.
module xillybus_rd_framer #(
    parameter int DEPTH_LOG2 = 9,
    parameter int MAX_LEN    = 256
) (
    input  logic        bus_clk,
    input  logic        rst_n,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    input  logic        user_r_open,
    input  logic        user_r_rden,
    output logic [31:0] user_r_data,
    output logic        user_r_empty,
    output logic        user_r_eof,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
);

    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, TRL, DISCARD} state_t;

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [14:0] MAX_CNT = 15'(MAX_LEN);

    state_t              state;
    logic [31:0]         mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic [14:0]         count;
    logic [15:0]         csum;
    logic                trunc;
    logic                full;
    logic                rd_fire;
    logic                wr_room;
    logic                accept;
    logic                at_max;
    logic                wr_en;
    logic [31:0]         wr_data;
    logic [15:0]         word_fold;

    // Extra pointer MSB tells a full FIFO from an empty one.
    assign user_r_empty = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                          (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign rd_fire      = user_r_open & user_r_rden & ~user_r_empty;
    assign wr_room      = ~full | rd_fire;
    assign user_r_eof   = 1'b0;
    assign accept       = s_valid & s_ready;
    assign word_fold    = s_data[31:16] ^ s_data[15:0];
    assign at_max       = (count + 15'd1) == MAX_CNT;

    // Closed stream in IDLE sinks input so the readout side never stalls.
    always_comb begin
        s_ready = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE:    s_ready = ~user_r_open;
                PAYLOAD: s_ready = user_r_open & wr_room;
                DISCARD: s_ready = 1'b1;
                default: s_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        if (rst_n && user_r_open) begin
            case (state)
                HDR: begin
                    wr_en   = wr_room;
                    wr_data = {16'hCEC0, frame_cnt};
                end
                PAYLOAD: begin
                    wr_en   = accept;
                    wr_data = s_data;
                end
                TRL: begin
                    wr_en   = wr_room;
                    wr_data = {trunc, count, csum};
                end
                default: begin
                    wr_en   = 1'b0;
                    wr_data = '0;
                end
            endcase
        end
    end

    always_ff @(posedge bus_clk) begin
        if (wr_en) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            user_r_data <= '0;
            frame_cnt   <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            csum        <= '0;
            trunc       <= 1'b0;
        end else begin
            if (!user_r_open) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_fire) begin
                    user_r_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
                    rd_ptr      <= rd_ptr + 1'b1;
                end
            end

            if (accept && (state == IDLE || state == DISCARD) && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (user_r_open && s_valid) begin
                        state <= HDR;
                    end
                end
                HDR: begin
                    count <= '0;
                    csum  <= '0;
                    if (!user_r_open) begin
                        state <= DISCARD;
                    end else if (wr_room) begin
                        state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!user_r_open) begin
                        state <= DISCARD;
                    end else if (accept) begin
                        count <= count + 15'd1;
                        csum  <= csum ^ word_fold;
                        if (s_last) begin
                            trunc <= 1'b0;
                            state <= TRL;
                        end else if (at_max) begin
                            trunc <= 1'b1;
                            state <= TRL;
                        end
                    end
                end
                TRL: begin
                    if (!user_r_open) begin
                        state <= IDLE;
                    end else if (wr_room) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= trunc ? DISCARD : IDLE;
                    end
                end
                DISCARD: begin
                    if ((accept && s_last) || !user_r_open) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xillybus_rd_framer.sv
// Randomized bench for xillybus_rd_framer: two instances (small FIFO, and
// MAX_LEN=4) share one stimulus bus selected by sel; a frame-level model predicts reads.
module tb_xillybus_rd_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, s_valid, s_last, open, rden, sel;
    logic [31:0] s_data;

    logic        rdy_a, rdy_b, emp_a, emp_b, eof_a, eof_b;
    logic [31:0] dat_a, dat_b;
    logic [15:0] fc_a, fc_b, dc_a, dc_b;

    logic        s_ready, user_r_empty, user_r_eof;
    logic [31:0] user_r_data;
    logic [15:0] frame_cnt, drop_cnt;

    assign s_ready      = sel ? rdy_b : rdy_a;
    assign user_r_empty = sel ? emp_b : emp_a;
    assign user_r_eof   = sel ? eof_b : eof_a;
    assign user_r_data  = sel ? dat_b : dat_a;
    assign frame_cnt    = sel ? fc_b  : fc_a;
    assign drop_cnt     = sel ? dc_b  : dc_a;

    xillybus_rd_framer #(.DEPTH_LOG2(4), .MAX_LEN(256)) dut_a (
        .bus_clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid & ~sel),
        .s_last(s_last), .s_ready(rdy_a), .user_r_open(open & ~sel),
        .user_r_rden(rden & ~sel), .user_r_data(dat_a), .user_r_empty(emp_a),
        .user_r_eof(eof_a), .frame_cnt(fc_a), .drop_cnt(dc_a)
    );

    xillybus_rd_framer #(.DEPTH_LOG2(9), .MAX_LEN(4)) dut_b (
        .bus_clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid & sel),
        .s_last(s_last), .s_ready(rdy_b), .user_r_open(open & sel),
        .user_r_rden(rden & sel), .user_r_data(dat_b), .user_r_empty(emp_b),
        .user_r_eof(eof_b), .frame_cnt(fc_b), .drop_cnt(dc_b)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] pay [512];
    logic        lastf [512];
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    logic [31:0] last_rd = '0;
    int          seq_m [2];
    int          drop_m [2];

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic make_frame(input int from, input int len);
        for (int i = 0; i < len; i++) begin
            pay[from+i]   = $urandom;
            lastf[from+i] = (i == len - 1);
        end
    endtask

    // Expected FIFO contents for one frame, from the frame-format rules.
    task automatic model_frame(input int inst, input int from, input int len);
        int ml;
        int k;
        logic [15:0] cs;
        ml = (inst != 0) ? 4 : 256;
        k  = (len < ml) ? len : ml;
        cs = '0;
        exp_q.push_back({16'hCEC0, 16'(seq_m[inst])});
        for (int i = 0; i < k; i++) begin
            exp_q.push_back(pay[from+i]);
            cs = cs ^ pay[from+i][31:16] ^ pay[from+i][15:0];
        end
        exp_q.push_back({(len > ml) ? 1'b1 : 1'b0, 15'(k), cs});
        seq_m[inst]  = seq_m[inst] + 1;
        drop_m[inst] = drop_m[inst] + (len - k);
    endtask

    task automatic send_words(input int from, input int to, input int budget, output int sent);
        int waited;
        sent = from;
        for (int i = from; i < to; i++) begin
            s_data  = pay[i];
            s_last  = lastf[i];
            s_valid = 1'b1;
            waited  = 0;
            forever begin
                #1;
                if (s_ready) begin
                    sync();
                    break;
                end
                sync();
                waited++;
                if (waited > budget) begin
                    s_valid = 1'b0;
                    s_last  = 1'b0;
                    return;
                end
            end
            sent = i + 1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic read_n(input int n, input bit random_rd, input int budget);
        int  issued;
        bit  pf;
        issued = 0;
        pf     = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (pf) got_q.push_back(user_r_data);
            if (got_q.size() >= n) break;
            rden = (issued < n) && (!random_rd || ($urandom_range(0, 1) == 1));
            #1;
            pf = rden && !user_r_empty;
            if (pf) issued++;
            sync();
        end
        rden = 1'b0;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL reset_s_ready[%0d]: got %0b want 0", s, s_ready); end
            vectors++; if (user_r_data !== 32'h0) begin miscompares++; $display("FAIL reset_data[%0d]: got %h want 0", s, user_r_data); end
            vectors++; if (user_r_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty[%0d]: got %0b want 1", s, user_r_empty); end
            vectors++; if (user_r_eof !== 1'b0) begin miscompares++; $display("FAIL reset_eof[%0d]: got %0b want 0", s, user_r_eof); end
            vectors++; if (frame_cnt !== 16'h0 || drop_cnt !== 16'h0) begin miscompares++; $display("FAIL reset_cnts[%0d]: got %h/%h want 0/0", s, frame_cnt, drop_cnt); end
        end
        sel   = 1'b0;
        rst_n = 1'b1;
        sync();
        #1;
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL idle_open_s_ready: got %0b want 0", s_ready); end
        sync();
    endtask

    task automatic test_single_frame();
        int sent;
        pay[0] = 32'h00010002; pay[1] = 32'h00030004; pay[2] = 32'h0005000C;
        lastf[0] = 1'b0; lastf[1] = 1'b0; lastf[2] = 1'b1;
        model_frame(0, 0, 3);
        fork
            send_words(0, 3, 100, sent);
            read_n(5, 1'b0, 200);
        join
        vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL single_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL single_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        vectors++; if (got_q.size() > 4 && got_q[4] !== 32'h0003000D) begin miscompares++; $display("FAIL single_trailer: got %h want 0003000d", got_q[4]); end
        vectors++; if (frame_cnt !== 16'd1) begin miscompares++; $display("FAIL single_frame_cnt: got %0d want 1", frame_cnt); end
        last_rd = exp_q[exp_q.size()-1];
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_back_to_back();
        int sent;
        int total;
        int nframes;
        total   = 0;
        nframes = 6;
        for (int f = 0; f < nframes; f++) begin
            int len;
            len = $urandom_range(1, 12);
            make_frame(total, len);
            model_frame(0, total, len);
            total += len;
        end
        fork
            send_words(0, total, 200, sent);
            read_n(total + 2 * nframes, 1'b1, 2000);
        join
        vectors++; if (sent !== total) begin miscompares++; $display("FAIL b2b_sent: got %0d want %0d", sent, total); end
        vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL b2b_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL b2b_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        vectors++; if (frame_cnt !== 16'(seq_m[0]) || drop_cnt !== 16'(drop_m[0])) begin miscompares++; $display("FAIL b2b_cnts: got %0d/%0d want %0d/%0d", frame_cnt, drop_cnt, seq_m[0], drop_m[0]); end
        last_rd = exp_q[exp_q.size()-1];
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_truncation();
        int sent;
        sel = 1'b1;
        sync();
        make_frame(0, 6);
        make_frame(6, 4);
        make_frame(10, 2);
        model_frame(1, 0, 6);
        model_frame(1, 6, 4);
        model_frame(1, 10, 2);
        fork
            send_words(0, 12, 200, sent);
            read_n(16, 1'b1, 1000);
        join
        vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL trunc_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL trunc_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        vectors++; if (got_q.size() > 5 && got_q[5][31:16] !== 16'h8004) begin miscompares++; $display("FAIL trunc_flag_count: got %h want 8004", got_q[5][31:16]); end
        vectors++; if (got_q.size() > 6 && got_q[6] !== 32'hCEC00001) begin miscompares++; $display("FAIL trunc_next_hdr: got %h want cec00001", got_q[6]); end
        vectors++; if (drop_cnt !== 16'd2) begin miscompares++; $display("FAIL trunc_drop_cnt: got %0d want 2", drop_cnt); end
        vectors++; if (frame_cnt !== 16'd3) begin miscompares++; $display("FAIL trunc_frame_cnt: got %0d want 3", frame_cnt); end
        exp_q.delete(); got_q.delete();
        sel = 1'b0;
        sync();
    endtask

    task automatic test_backpressure();
        int sent;
        rden = 1'b0;
        make_frame(0, 20);
        model_frame(0, 0, 20);
        send_words(0, 20, 12, sent);
        vectors++; if (sent !== 15) begin miscompares++; $display("FAIL bp_accepted: got %0d want 15", sent); end
        #1;
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL bp_s_ready: got %0b want 0", s_ready); end
        sync();
        fork
            send_words(15, 20, 200, sent);
            read_n(22, 1'b0, 500);
        join
        vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL bp_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL bp_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        last_rd = exp_q[exp_q.size()-1];
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_close_mid_frame();
        int sent;
        int seq_before;
        seq_before = seq_m[0];
        rden = 1'b0;
        make_frame(0, 6);
        send_words(0, 2, 20, sent);
        vectors++; if (sent !== 2) begin miscompares++; $display("FAIL close_sent: got %0d want 2", sent); end
        #1;
        vectors++; if (user_r_empty !== 1'b0) begin miscompares++; $display("FAIL close_pre_empty: got %0b want 0", user_r_empty); end
        sync();
        open = 1'b0;
        sync();
        #1;
        vectors++; if (user_r_empty !== 1'b1) begin miscompares++; $display("FAIL close_empty: got %0b want 1", user_r_empty); end
        sync();
        send_words(2, 6, 20, sent);
        drop_m[0] = drop_m[0] + 4;
        vectors++; if (drop_cnt !== 16'(drop_m[0])) begin miscompares++; $display("FAIL close_drop_cnt: got %0d want %0d", drop_cnt, drop_m[0]); end
        vectors++; if (frame_cnt !== 16'(seq_before)) begin miscompares++; $display("FAIL close_frame_cnt: got %0d want %0d", frame_cnt, seq_before); end
        open = 1'b1;
        sync();
        make_frame(0, 1);
        model_frame(0, 0, 1);
        fork
            send_words(0, 1, 100, sent);
            read_n(3, 1'b1, 300);
        join
        vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL reopen_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL reopen_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        last_rd = exp_q[exp_q.size()-1];
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_empty_read();
        int sent;
        for (int i = 0; i < 6; i++) begin
            rden = 1'b1;
            sync();
            vectors++; if (user_r_empty !== 1'b1 || user_r_data !== last_rd) begin miscompares++; $display("FAIL empty_read[%0d]: got %0b/%h want 1/%h", i, user_r_empty, user_r_data, last_rd); end
        end
        rden = 1'b0;
        make_frame(0, 2);
        model_frame(0, 0, 2);
        fork
            send_words(0, 2, 100, sent);
            read_n(4, 1'b1, 300);
        join
        vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL empty_after_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL empty_after_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        #1;
        vectors++; if (user_r_empty !== 1'b1) begin miscompares++; $display("FAIL empty_after_drain: got %0b want 1", user_r_empty); end
        sync();
        last_rd = exp_q[exp_q.size()-1];
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid_payload();
        int sent;
        rden = 1'b0;
        make_frame(0, 10);
        send_words(0, 3, 20, sent);
        vectors++; if (sent !== 3) begin miscompares++; $display("FAIL rstmid_sent: got %0d want 3", sent); end
        rst_n = 1'b0;
        sync();
        vectors++; if (s_ready !== 1'b0 || user_r_data !== 32'h0 || user_r_empty !== 1'b1) begin miscompares++; $display("FAIL rstmid_outs: got %0b/%h/%0b want 0/0/1", s_ready, user_r_data, user_r_empty); end
        vectors++; if (frame_cnt !== 16'h0 || drop_cnt !== 16'h0 || user_r_eof !== 1'b0) begin miscompares++; $display("FAIL rstmid_cnts: got %0d/%0d/%0b want 0/0/0", frame_cnt, drop_cnt, user_r_eof); end
        rst_n = 1'b1;
        seq_m[0] = 0; seq_m[1] = 0; drop_m[0] = 0; drop_m[1] = 0;
        sync();
        make_frame(0, 2);
        model_frame(0, 0, 2);
        fork
            send_words(0, 2, 100, sent);
            read_n(4, 1'b0, 300);
        join
        vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rstmid_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rstmid_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; open = 1'b1; rden = 1'b0;
        s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        seq_m[0] = 0; seq_m[1] = 0; drop_m[0] = 0; drop_m[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_truncation();
        test_backpressure();
        test_close_mid_frame();
        test_empty_read();
        test_reset_mid_payload();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors applied", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
